// File: rtl/seq_match_if.sv
// Bundle between the sequence detector side and the match statistics block.
// gap_valid qualifies last_gap for exactly one cycle; there is no backpressure.
interface seq_match_if #(
    parameter int CNT_W = 16,
    parameter int GAP_W = 16
);
    logic             match_in;
    logic             clear;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [GAP_W-1:0] last_gap;
    logic             gap_valid;
    logic             led;
    logic             fsm_state;

    modport master (
        output match_in, clear,
        input  count, overflow, last_gap, gap_valid, led, fsm_state
    );

    modport slave (
        input  match_in, clear,
        output count, overflow, last_gap, gap_valid, led, fsm_state
    );
endinterface

// File: rtl/seq_match_counter.sv
// Turns detector match levels into single events, counts them, times the gap
// between consecutive events and stretches each event into an LED pulse.
module seq_match_counter #(
    parameter int CNT_W   = 16,
    parameter int GAP_W   = 16,
    parameter int STRETCH = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    seq_match_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } led_state_t;

    localparam int               SW      = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam logic [SW-1:0]    RELOAD  = SW'(STRETCH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [GAP_W-1:0] GAP_MAX = '1;

    logic             match_q;
    logic             match_q2;
    logic             evt;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] last_gap_q;
    logic             gap_valid_q;
    logic             armed;
    logic             led_q;
    led_state_t       state_q;
    led_state_t       state_d;
    logic [SW-1:0]    stretch_q;
    logic [SW-1:0]    stretch_d;

    assign evt = match_q & ~match_q2;

    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        case (state_q)
            IDLE: begin
                if (evt) begin
                    state_d   = HOLD;
                    stretch_d = RELOAD;
                end
            end
            HOLD: begin
                if (evt) begin
                    stretch_d = RELOAD;
                end else if (stretch_q != '0) begin
                    stretch_d = stretch_q - SW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q  <= 1'b0;
            match_q2 <= 1'b0;
        end else begin
            match_q  <= bus.match_in;
            match_q2 <= match_q;
        end
    end

    // clear wins over a same-cycle event; the edge detector keeps sampling
    // so a level still high afterwards does not count again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            gap_cnt     <= '0;
            last_gap_q  <= '0;
            gap_valid_q <= 1'b0;
            armed       <= 1'b0;
            state_q     <= IDLE;
            stretch_q   <= '0;
            led_q       <= 1'b0;
        end else if (bus.clear) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            gap_cnt     <= '0;
            last_gap_q  <= '0;
            gap_valid_q <= 1'b0;
            armed       <= 1'b0;
            state_q     <= IDLE;
            stretch_q   <= '0;
            led_q       <= 1'b0;
        end else begin
            gap_valid_q <= 1'b0;
            state_q     <= state_d;
            stretch_q   <= stretch_d;
            led_q       <= (state_d == HOLD);
            if (evt) begin
                if (count_q != CNT_MAX) begin
                    count_q <= count_q + CNT_W'(1);
                end else begin
                    overflow_q <= 1'b1;
                end
                if (armed) begin
                    last_gap_q  <= (gap_cnt == GAP_MAX) ? GAP_MAX : gap_cnt + GAP_W'(1);
                    gap_valid_q <= 1'b1;
                end
                armed   <= 1'b1;
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_MAX) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.last_gap  = last_gap_q;
    assign bus.gap_valid = gap_valid_q;
    assign bus.led       = led_q;
    assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_seq_match_counter.sv
// Directed bench: a wide instance (a) and a narrow saturating instance (b)
// share the same match_in/clear stimulus.
module tb_seq_match_counter;

    logic clk;
    logic rst;
    logic match_in;
    logic clear;

    int n_checks;
    int n_fail;

    seq_match_if #(.CNT_W(16), .GAP_W(16)) ifa ();
    seq_match_if #(.CNT_W(4),  .GAP_W(3))  ifb ();

    assign ifa.match_in = match_in;
    assign ifa.clear    = clear;
    assign ifb.match_in = match_in;
    assign ifb.clear    = clear;

    seq_match_counter #(.CNT_W(16), .GAP_W(16), .STRETCH(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    seq_match_counter #(.CNT_W(4), .GAP_W(3), .STRETCH(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse();
        match_in = 1'b1;
        tick(1);
        match_in = 1'b0;
        tick(1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " a.count"},     32'(ifa.count),     0);
        chk({tag, " a.overflow"},  32'(ifa.overflow),  0);
        chk({tag, " a.last_gap"},  32'(ifa.last_gap),  0);
        chk({tag, " a.gap_valid"}, 32'(ifa.gap_valid), 0);
        chk({tag, " a.led"},       32'(ifa.led),       0);
        chk({tag, " b.count"},     32'(ifb.count),     0);
        chk({tag, " b.overflow"},  32'(ifb.overflow),  0);
        chk({tag, " b.led"},       32'(ifb.led),       0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        match_in = 1'b0;
        clear    = 1'b0;
        tick(2);
        chk_all_zero("reset");
        chk("reset a.fsm_state", 32'(ifa.fsm_state), 0);
        rst = 1'b0;
        tick(2);

        // level held for three sampled edges -> one event, LED for 4 cycles
        match_in = 1'b1;
        tick(1);
        chk("latency count", 32'(ifa.count), 0);
        chk("latency led",   32'(ifa.led),   0);
        tick(1);
        chk("edge count",      32'(ifa.count),     1);
        chk("edge led",        32'(ifa.led),       1);
        chk("edge first gv",   32'(ifa.gap_valid), 0);
        tick(1);
        chk("edge hold count", 32'(ifa.count), 1);
        match_in = 1'b0;
        tick(1);
        chk("edge led3", 32'(ifa.led), 1);
        tick(1);
        chk("edge led4", 32'(ifa.led), 1);
        chk("edge count2", 32'(ifa.count), 1);
        tick(1);
        chk("edge led off", 32'(ifa.led), 0);
        chk("edge final count", 32'(ifa.count), 1);

        // gap of 7 after a clear
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk_all_zero("clear1");
        tick(2);
        match_in = 1'b1;
        tick(1);
        match_in = 1'b0;
        tick(1);
        chk("gap first gv",    32'(ifa.gap_valid), 0);
        chk("gap first count", 32'(ifa.count),     1);
        tick(5);
        match_in = 1'b1;
        tick(1);
        match_in = 1'b0;
        chk("gap pre gv", 32'(ifa.gap_valid), 0);
        tick(1);
        chk("gap7 a.last_gap", 32'(ifa.last_gap),  7);
        chk("gap7 b.last_gap", 32'(ifb.last_gap),  7);
        chk("gap7 gv",         32'(ifa.gap_valid), 1);
        chk("gap7 count",      32'(ifa.count),     2);
        tick(1);
        chk("gap7 gv drop", 32'(ifa.gap_valid), 0);
        chk("gap7 hold",    32'(ifa.last_gap),  7);
        tick(6);

        // 1,0,1 -> gap 2, and LED retrigger
        match_in = 1'b1;
        tick(1);
        match_in = 1'b0;
        tick(1);
        chk("retrig led on", 32'(ifa.led), 1);
        match_in = 1'b1;
        tick(1);
        match_in = 1'b0;
        chk("retrig led mid", 32'(ifa.led), 1);
        tick(1);
        chk("gap2 a.last_gap", 32'(ifa.last_gap),  2);
        chk("gap2 b.last_gap", 32'(ifb.last_gap),  2);
        chk("gap2 gv",         32'(ifa.gap_valid), 1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("retrig led held", 32'(ifa.led), 1);
        end
        tick(1);
        chk("retrig led off", 32'(ifa.led), 0);

        // saturation
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk_all_zero("clear2");
        for (int i = 0; i < 15; i++) pulse();
        chk("sat15 b.count",    32'(ifb.count),    15);
        chk("sat15 b.overflow", 32'(ifb.overflow), 0);
        pulse();
        chk("sat16 b.count",    32'(ifb.count),    15);
        chk("sat16 b.overflow", 32'(ifb.overflow), 1);
        chk("sat16 a.count",    32'(ifa.count),    16);
        chk("sat16 a.overflow", 32'(ifa.overflow), 0);
        tick(18);
        match_in = 1'b1;
        tick(1);
        match_in = 1'b0;
        tick(1);
        chk("gap20 a.last_gap", 32'(ifa.last_gap),  20);
        chk("gap20 b.last_gap", 32'(ifb.last_gap),  7);
        chk("gap20 b.gv",       32'(ifb.gap_valid), 1);
        chk("gap20 b.overflow", 32'(ifb.overflow),  1);
        chk("gap20 a.count",    32'(ifa.count),     17);

        // clear coincident with an event, level held high afterwards
        match_in = 1'b1;
        tick(1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk_all_zero("clear_prio");
        tick(3);
        chk("clear level count", 32'(ifa.count), 0);
        chk("clear level led",   32'(ifa.led),   0);
        match_in = 1'b0;
        tick(1);
        pulse();
        chk("post clear count", 32'(ifa.count),     1);
        chk("post clear gv",    32'(ifa.gap_valid), 0);
        chk("post clear led",   32'(ifa.led),       1);

        // asynchronous reset mid-cycle with led=1, count=5
        for (int i = 0; i < 4; i++) pulse();
        chk("pre rst count", 32'(ifa.count), 5);
        chk("pre rst led",   32'(ifa.led),   1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("async rst");
        tick(1);
        rst = 1'b0;
        tick(2);
        chk("after rst count", 32'(ifa.count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
